// File: rtl/nav_cmd_encoder.sv
// Navigation-pulse to fractal command-bus transmitter: one-entry event slot, shadow
// x/y/zoom registers and a serialiser that holds each command then pads with NOPs.
module nav_cmd_encoder #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter logic [17:0] STEP_BASE   = 18'h0_4000,
  parameter int unsigned MAX_ZOOM    = 15,
  parameter bit          AUTO_SYNC   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nav_left,
  input  logic        nav_right,
  input  logic        nav_up,
  input  logic        nav_down,
  input  logic        zoom_in,
  input  logic        zoom_out,
  input  logic        resync,
  output logic [21:0] cmd,
  output logic        busy,
  output logic [17:0] x_shadow,
  output logic [17:0] y_shadow,
  output logic [4:0]  zoom_shadow,
  output logic        overflow
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SEND, S_GAP} state_e;
  typedef enum logic [2:0] {
    EV_NONE, EV_RESYNC, EV_ZIN, EV_ZOUT, EV_LEFT, EV_RIGHT, EV_UP, EV_DOWN
  } ev_e;

  localparam logic [1:0]  OP_X     = 2'd1;
  localparam logic [1:0]  OP_Y     = 2'd2;
  localparam logic [1:0]  OP_Z     = 2'd3;
  localparam logic [15:0] HOLD_END = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_END  = 16'(GAP_CYCLES - 1);
  localparam logic [4:0]  ZOOM_TOP = 5'(MAX_ZOOM);

  state_e      state_q, state_d;
  ev_e         pend_q, pend_d;
  ev_e         cur_q, cur_d;
  ev_e         ev;
  logic        armed_q;
  logic        ovf_q, ovf_d;
  logic [21:0] cmd_q, cmd_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        rs_q, rs_d;
  logic [17:0] x_q, x_d, y_q, y_d;
  logic [4:0]  z_q, z_d;
  logic [17:0] step, nx, ny;
  logic [4:0]  nz;
  logic [1:0]  first_op;

  function automatic logic [17:0] sat_step(input logic [17:0] v, input logic [17:0] s,
                                           input logic neg);
    logic [18:0] r;
    r = neg ? ({v[17], v} - {s[17], s}) : ({v[17], v} + {s[17], s});
    if (r[18] != r[17]) sat_step = r[18] ? 18'h2_0000 : 18'h1_FFFF;
    else                sat_step = r[17:0];
  endfunction

  function automatic logic [21:0] build_cmd(input logic [1:0] op, input logic [17:0] xv,
                                            input logic [17:0] yv, input logic [4:0] zv);
    logic [17:0] payload;
    case (op)
      OP_X:    payload = xv;
      OP_Y:    payload = yv;
      default: payload = {13'b0, zv};
    endcase
    build_cmd = {payload, 2'b00, op};
  endfunction

  // Auto-sync behaves exactly like a resync pulse on the first cycle out of reset.
  always_comb begin
    ev = EV_NONE;
    if (armed_q || resync) ev = EV_RESYNC;
    else if (zoom_in)      ev = EV_ZIN;
    else if (zoom_out)     ev = EV_ZOUT;
    else if (nav_left)     ev = EV_LEFT;
    else if (nav_right)    ev = EV_RIGHT;
    else if (nav_up)       ev = EV_UP;
    else if (nav_down)     ev = EV_DOWN;
  end

  // IDLE consumes a full slot on this edge, so a same-edge pulse sees it empty.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (state_q == S_IDLE) pend_d = EV_NONE;
    if (ev != EV_NONE) begin
      if (pend_d == EV_NONE) pend_d = ev;
      else                   ovf_d  = 1'b1;
    end
  end

  always_comb begin
    step     = STEP_BASE >> z_q;
    nx       = x_q;
    ny       = y_q;
    nz       = z_q;
    first_op = OP_X;
    case (cur_q)
      EV_ZIN:   begin nz = (z_q >= ZOOM_TOP) ? ZOOM_TOP : z_q + 5'd1; first_op = OP_Z; end
      EV_ZOUT:  begin nz = (z_q == 5'd0) ? 5'd0 : z_q - 5'd1;         first_op = OP_Z; end
      EV_LEFT:  nx = sat_step(x_q, step, 1'b1);
      EV_RIGHT: nx = sat_step(x_q, step, 1'b0);
      EV_UP:    begin ny = sat_step(y_q, step, 1'b0); first_op = OP_Y; end
      EV_DOWN:  begin ny = sat_step(y_q, step, 1'b1); first_op = OP_Y; end
      default:  first_op = OP_X;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rs_d    = rs_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cmd_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (pend_q != EV_NONE) begin
          cur_d   = pend_q;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        if (cur_q == EV_RESYNC || nx != x_q || ny != y_q || nz != z_q) begin
          x_d     = nx;
          y_d     = ny;
          z_d     = nz;
          rs_d    = (cur_q == EV_RESYNC);
          op_d    = first_op;
          cnt_d   = '0;
          cmd_d   = build_cmd(first_op, nx, ny, nz);
          state_d = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (cnt_q == HOLD_END) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
          cmd_d = cmd_q;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_END) begin
          cnt_d = '0;
          // A resync walks x -> y -> zoom; every other list has a single entry.
          if (rs_q && op_q != OP_Z) begin
            op_d    = op_q + 2'd1;
            cmd_d   = build_cmd(op_q + 2'd1, x_q, y_q, z_q);
            state_d = S_SEND;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pend_q  <= EV_NONE;
      cur_q   <= EV_NONE;
      armed_q <= AUTO_SYNC;
      ovf_q   <= 1'b0;
      cmd_q   <= '0;
      cnt_q   <= '0;
      op_q    <= OP_X;
      rs_q    <= 1'b0;
      x_q     <= 18'h3_0000;
      y_q     <= 18'h1_0000;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cur_q   <= cur_d;
      armed_q <= 1'b0;
      ovf_q   <= ovf_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  assign cmd         = cmd_q;
  assign busy        = (state_q != S_IDLE);
  assign x_shadow    = x_q;
  assign y_shadow    = y_q;
  assign zoom_shadow = z_q;
  assign overflow    = ovf_q;

endmodule

// File: doc/nav_cmd_encoder.md
Name: nav_cmd_encoder

Overview:
- Hardware-side transmitter for the 22-bit fractal parameter command bus: {payload[17:0], opcode[3:0]}.
- Opcodes: 1 = xCoord, 2 = yCoord, 3 = zoom (payload[4:0] only), 0 = NOP.
- Converts single-cycle navigation pulses (pan / zoom / resync) into updated x/y/zoom values and serialises the resulting commands onto the bus.
- Keeps shadow copies of the values it last sent, which are always equal to the far-end parameter registers.

Parameters:
- HOLD_CYCLES, 2, cycles each non-NOP command is held on cmd (>=1).
- GAP_CYCLES, 1, NOP cycles after each command (>=1).
- STEP_BASE, 18'h0_4000, pan step at zoom 0 (0.25 in signed 2.16).
- MAX_ZOOM, 15, upper clamp for zoom.
- AUTO_SYNC, 1, 1 = issue a resync automatically after reset deasserts.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- nav_left  in  1  pulse: x -= step
- nav_right  in  1  pulse: x += step
- nav_up  in  1  pulse: y += step
- nav_down  in  1  pulse: y -= step
- zoom_in  in  1  pulse: zoom += 1
- zoom_out  in  1  pulse: zoom -= 1
- resync  in  1  pulse: resend x, y, zoom
- cmd  out  22  command bus, registered
- busy  out  1  FSM not in IDLE
- x_shadow  out  18  signed 2.16 current x
- y_shadow  out  18  signed 2.16 current y
- zoom_shadow  out  5  current zoom, 0..MAX_ZOOM
- overflow  out  1  sticky: an event was dropped because the pending slot was full

Behaviour:
- Reset values:
  - cmd = 0; busy = 0; overflow = 0.
  - x_shadow = 18'h3_0000; y_shadow = 18'h1_0000; zoom_shadow = 0.
  - Pending slot empty; FSM = IDLE.
  - If AUTO_SYNC = 1, the pending slot is loaded with RESYNC on the first cycle after reset deasserts.
- Reset mid-operation: cmd returns to 0 at the next edge; all state returns to the reset values above. The partial command sequence is abandoned and not replayed.
- Event capture, every cycle:
  - Priority: resync > zoom_in > zoom_out > nav_left > nav_right > nav_up > nav_down.
  - Only the highest-priority asserted pulse is taken; lower pulses asserted in the same cycle are dropped silently.
  - The one-entry pending slot is filled if empty. If it is full, the event is dropped and overflow is set. overflow clears only on reset.
  - Capture continues while busy.
- FSM states: IDLE, APPLY, SEND, GAP.
- IDLE:
  - Pending full -> APPLY; pending is cleared on the same edge.
  - If a new pulse arrives on that same edge, it fills the now-empty slot.
- APPLY (1 cycle):
  - step = STEP_BASE >> zoom_shadow (logical shift).
  - Compute the new value with an 19-bit intermediate, saturating to [18'h2_0000, 18'h1_FFFF].
  - zoom_in clamps at MAX_ZOOM; zoom_out clamps at 0.
  - If the clamped value equals the shadow value: no command; -> IDLE.
  - Otherwise: update the shadow and build the send list, then -> SEND.
    - Pan events: one entry (x or y).
    - Zoom events: one entry (zoom).
    - RESYNC: x, y, zoom, in that order.
- SEND:
  - cmd = {payload, opcode}; zoom payload is {13'b0, zoom}.
  - Held for exactly HOLD_CYCLES cycles, then -> GAP.
- GAP:
  - cmd = 22'h0 for GAP_CYCLES cycles.
  - Then -> SEND for the next list entry, or -> IDLE when the list is exhausted.
- Timing: pulse sampled at edge N -> APPLY after N+1 -> cmd valid after N+2. busy is high from N+1 until the FSM re-enters IDLE.
- The payload always reflects the shadow value at the time of sending. Shadows change only in APPLY.
- cmd is never non-zero outside SEND. Two consecutive commands are always separated by at least GAP_CYCLES NOP cycles.

Test Plan:
- Reset release, AUTO_SYNC = 1, HOLD = 2, GAP = 1 -> cmd sequence: 22'h30_0001 x2, 0 x1, 22'h10_0002 x2, 0 x1, 22'h00_0003 x2, 0; busy then low; overflow = 0.
- nav_right at zoom 0 -> x_shadow = 18'h3_4000; cmd = 22'h34_0001 for 2 cycles, first appearing 2 cycles after the pulse edge.
- zoom_in x2, then nav_up -> zoom cmds 22'h00_0013 and 22'h00_0023; step = 18'h1000; y_shadow = 18'h1_1000; cmd = 22'h11_0002.
- Saturation and clamp:
  - x_shadow = 18'h1_FFF0 with nav_right -> x_shadow = 18'h1_FFFF, cmd 22'h1F_FFF1.
  - zoom_out at zoom 0 -> no command; cmd stays 0; busy high for exactly 1 cycle.
- While busy, with the slot empty, pulse nav_left then nav_down on consecutive cycles:
  - nav_left is executed after the current sequence; nav_down is dropped; overflow = 1.
  - Simultaneous zoom_in + nav_left -> only zoom_in is taken.
- reset asserted in the middle of the x hold during a resync -> next cycle cmd = 0 and shadows at reset values; after release, AUTO_SYNC sequence restarts from x.
